// File: rtl/mac_pkg.sv
// Shared types, default widths and the round/saturate helper for the MAC processing element.
// sat_round works on a widened accumulator so one function serves every ACC_W/DATA_W (<=127/<=64).
package mac_pkg;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_FRAC_BITS = 8;
    localparam int unsigned DEF_ACC_W     = 40;
    localparam int unsigned MAX_ACC_W     = 127;
    localparam int unsigned MAX_DATA_W    = 64;

    typedef logic signed [DEF_DATA_W-1:0]   lane_t;
    typedef logic signed [2*DEF_DATA_W-1:0] prod_t;

    typedef struct packed {
        logic                  sat;
        logic [MAX_DATA_W-1:0] data;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Round half-up at frac_bits, then clip to a signed data_w range.
    function automatic sat_res_t sat_round(input logic signed [MAX_ACC_W:0] acc,
                                           input int unsigned data_w,
                                           input int unsigned frac_bits);
        logic signed [MAX_ACC_W:0] one;
        logic signed [MAX_ACC_W:0] r;
        logic signed [MAX_ACC_W:0] hi;
        logic signed [MAX_ACC_W:0] lo;
        sat_res_t                  res;
        one = {{MAX_ACC_W{1'b0}}, 1'b1};
        if (frac_bits == 0) begin
            r = acc;
        end else begin
            r = (acc + (one <<< (frac_bits - 1))) >>> frac_bits;
        end
        hi = (one <<< (data_w - 1)) - one;
        lo = -(one <<< (data_w - 1));
        res.sat  = 1'b0;
        res.data = r[MAX_DATA_W-1:0];
        if (r > hi) begin
            res.sat  = 1'b1;
            res.data = hi[MAX_DATA_W-1:0];
        end else if (r < lo) begin
            res.sat  = 1'b1;
            res.data = lo[MAX_DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// LANES registered signed multipliers (S1) feeding a registered adder tree (S2).
// Both stages freeze when i_hold is high; first/last tags travel alongside the data.
module mac_lane_tree
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LANES  = 4,
    localparam int unsigned PROD_W = 2 * DATA_W,
    localparam int unsigned SUM_W  = 2 * DATA_W + clog2(LANES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_hold,
    input  logic                           i_valid,
    input  logic                           i_first,
    input  logic                           i_last,
    input  logic [LANES*DATA_W-1:0]        i_a,
    input  logic [LANES*DATA_W-1:0]        i_b,
    output logic                           o_valid,
    output logic                           o_first,
    output logic                           o_last,
    output logic signed [SUM_W-1:0]        o_sum,
    output logic                           o_busy
);

    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [PROD_W-1:0] r_prod [LANES];
    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_last;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [SUM_W-1:0]  r_sum;
    logic                     r_s2_valid;
    logic                     r_s2_first;
    logic                     r_s2_last;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DATA_W-1:0] w_a;
        logic signed [DATA_W-1:0] w_b;
        assign w_a       = i_a[g*DATA_W +: DATA_W];
        assign w_b       = i_b[g*DATA_W +: DATA_W];
        assign w_prod[g] = PROD_W'(w_a) * PROD_W'(w_b);
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_sum = w_sum + SUM_W'(r_prod[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_sum      <= '0;
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
        end else if (!i_hold) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                r_prod[i] <= w_prod[i];
            end
            r_s1_valid <= i_valid;
            r_s1_first <= i_first;
            r_s1_last  <= i_last;
            r_sum      <= w_sum;
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_first = r_s2_first;
    assign o_last  = r_s2_last;
    assign o_sum   = r_sum;
    assign o_busy  = r_s1_valid || r_s2_valid;

endmodule

// File: rtl/mac_array_pe.sv
// Multi-lane MAC processing element: input register, lane tree, accumulator, round/saturate.
// Define MAC_PE_RELU_EN to clamp negative results to zero after saturation.
module mac_array_pe
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LANES     = 4,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sat,
    output logic                    busy
);

    localparam int unsigned SUM_W = 2 * DATA_W + clog2(LANES);

    logic                    w_stall;
    logic                    w_accept;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        w_cur_len;
    logic                    w_first;
    logic                    w_last;

    logic                    r_in_valid;
    logic                    r_in_first;
    logic                    r_in_last;
    logic [LANES*DATA_W-1:0] r_in_a;
    logic [LANES*DATA_W-1:0] r_in_b;

    logic                    w_tree_valid;
    logic                    w_tree_first;
    logic                    w_tree_last;
    logic signed [SUM_W-1:0] w_tree_sum;
    logic                    w_tree_busy;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_acc_open;
    logic signed [ACC_W-1:0] w_sum_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [MAX_ACC_W:0] w_acc_wide;
    sat_res_t                w_res;
    logic [DATA_W-1:0]       w_out_data;
    logic                    w_out_sat;
    logic                    w_unused_hi;

    logic                    r_out_valid;
    logic [DATA_W-1:0]       r_out_data;
    logic                    r_out_sat;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !rst && !w_stall;
    assign w_accept = in_valid && in_ready;

    // A zero length is treated as a single-beat group.
    assign w_first   = (r_cnt == '0);
    assign w_cur_len = w_first ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : r_len;
    assign w_last    = (r_cnt == (w_cur_len - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_in_valid <= 1'b0;
            r_in_first <= 1'b0;
            r_in_last  <= 1'b0;
            r_in_a     <= '0;
            r_in_b     <= '0;
        end else if (!w_stall) begin
            r_in_valid <= w_accept;
            if (w_accept) begin
                if (w_first) begin
                    r_len <= w_cur_len;
                end
                r_cnt      <= w_last ? '0 : r_cnt + LEN_W'(1);
                r_in_first <= w_first;
                r_in_last  <= w_last;
                r_in_a     <= in_a;
                r_in_b     <= in_b;
            end
        end
    end

    mac_lane_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_lane_tree (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_stall),
        .i_valid (r_in_valid),
        .i_first (r_in_first),
        .i_last  (r_in_last),
        .i_a     (r_in_a),
        .i_b     (r_in_b),
        .o_valid (w_tree_valid),
        .o_first (w_tree_first),
        .o_last  (w_tree_last),
        .o_sum   (w_tree_sum),
        .o_busy  (w_tree_busy)
    );

    always_comb begin
        w_sum_ext  = ACC_W'(w_tree_sum);
        w_acc_next = w_tree_first ? w_sum_ext : r_acc + w_sum_ext;
        w_acc_wide = (MAX_ACC_W + 1)'(w_acc_next);
        w_res      = sat_round(w_acc_wide, DATA_W, FRAC_BITS);
        w_out_data = w_res.data[DATA_W-1:0];
        w_out_sat  = w_res.sat;
`ifdef MAC_PE_RELU_EN
        if (w_out_data[DATA_W-1]) begin
            w_out_data = '0;
            w_out_sat  = 1'b0;
        end
`else
`endif
    end

    assign w_unused_hi = ^w_res.data[MAX_DATA_W-1:DATA_W];

    // Without a stall the output register is either empty or being consumed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_acc_open  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (!w_stall) begin
            if (w_tree_valid) begin
                r_acc      <= w_acc_next;
                r_acc_open <= !w_tree_last;
            end
            if (w_tree_valid && w_tree_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_out_data;
                r_out_sat   <= w_out_sat;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign busy      = (r_cnt != '0) || r_in_valid || w_tree_busy || r_acc_open;

endmodule

// File: tb/tb_mac_array_pe.sv
// Scoreboard bench for mac_array_pe: directed groups push expected results, a monitor pops them.
module tb_mac_array_pe;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int LEN_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LEN_W-1:0]        cfg_len;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_a;
    logic [LANES*DATA_W-1:0] in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_sat;
    logic                    busy;

    typedef struct {
        logic [15:0] data;
        logic        sat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mac_array_pe #(
        .DATA_W    (16),
        .LANES     (4),
        .FRAC_BITS (8),
        .ACC_W     (40),
        .LEN_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Signed expectations; the ReLU build sees negatives as zero without saturation.
    task automatic push_exp(input logic [15:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.sat  = s;
`ifdef MAC_PE_RELU_EN
        if (d[15]) begin
            e.data = 16'h0000;
            e.sat  = 1'b0;
        end
`endif
        q.push_back(e);
    endtask

    task automatic send_beat(input logic [15:0] a0, input logic [15:0] ar,
                             input logic [15:0] b0, input logic [15:0] br,
                             input logic [15:0] len);
        int  guard;
        logic ok;
        guard    = 0;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = {ar, ar, ar, a0};
        in_b     = {br, br, br, b0};
        cfg_len  = len;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0, expected acceptance");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((q.size() != 0 || out_valid) && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got %0h, expected no output", out_data);
            end else begin
                e = q.pop_front();
                check("out_data", out_data, e.data);
                check("out_sat", out_sat, e.sat);
            end
        end
    end

    initial begin
        int g;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        cfg_len   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Basic single beat plus exact latency
        push_exp(16'h0800, 1'b0);
        send_beat(16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'd1);
        idle();
        @(posedge clk); #1; check("lat_t1", out_valid, 0);
        @(posedge clk); #1; check("lat_t2", out_valid, 0);
        @(posedge clk); #1; check("lat_t3", out_valid, 1);
        wait_drain();

        // Two back-to-back groups; cfg_len changes mid-group must be ignored
        push_exp(16'h0C00, 1'b0);
        push_exp(16'hF800, 1'b0);
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd3);
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd1);
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd7);
        send_beat(16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'd2);
        send_beat(16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'd0);
        idle();
        wait_drain();

        // Saturation both directions
        push_exp(16'h7FFF, 1'b1);
        send_beat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd1);
        push_exp(16'h8000, 1'b1);
        send_beat(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'd1);
        idle();
        wait_drain();

        // Rounding: +0.5 LSB up, just below stays, -0.504 rounds to -1
        push_exp(16'h0001, 1'b0);
        send_beat(16'h0001, 16'h0000, 16'h0080, 16'h0000, 16'd1);
        push_exp(16'h0000, 1'b0);
        send_beat(16'h0001, 16'h0000, 16'h007F, 16'h0000, 16'd1);
        push_exp(16'hFFFF, 1'b0);
        send_beat(16'hFFFF, 16'h0000, 16'h0081, 16'h0000, 16'd1);
        idle();
        wait_drain();

        // Zero length behaves as length one
        push_exp(16'h0400, 1'b0);
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd0);
        idle();
        wait_drain();

        // Bubbles inside a group
        push_exp(16'h0800, 1'b0);
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd2);
        idle();
        repeat (2) @(posedge clk);
        #1;
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd5);
        idle();
        wait_drain();

        // Backpressure with a second group in flight
        push_exp(16'h0400, 1'b0);
        push_exp(16'h0800, 1'b0);
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd1);
        send_beat(16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'd1);
        idle();
        out_ready = 1'b0;
        g = 0;
        while (!out_valid && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 16'h0400);
        end
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-group discards partial work
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd3);
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd3);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("mid_group_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_blocks_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_clears_busy", busy, 0);
        push_exp(16'h0400, 1'b0);
        send_beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'd1);
        idle();
        wait_drain();
        repeat (10) @(posedge clk);
        #1;
        check("final_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
